// File: rtl/key_sched_pkg.sv
// Shared types and round-schedule helpers for the C/D half-key register.
// Used by the top level to derive per-round rotate amounts.
package key_sched_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StRun
   } state_e;

   // Single-bit rotates on rounds 1, 2, the first round of the second half and the last round.
   function automatic int unsigned shift_amt(input int unsigned r, input int unsigned rounds);
      return (r == 1 || r == 2 || r == rounds / 2 + 1 || r == rounds) ? 1 : 2;
   endfunction

   function automatic int unsigned total_shift(input int unsigned rounds,
                                               input int unsigned half_w);
      return (2 * rounds - 4) % half_w;
   endfunction

endpackage

// File: rtl/key_half_rotate.sv
// Combinational rotate of one key half by 0..HALF_W-1 positions, left or right.
module key_half_rotate #(
   parameter int unsigned HALF_W = 28,
   parameter int unsigned AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1
) (
   input  logic [HALF_W-1:0] i_data,
   input  logic [AW-1:0]     i_amt,
   input  logic              i_right,
   output logic [HALF_W-1:0] o_data
);

   logic [2*HALF_W-1:0] w_dbl;
   logic [2*HALF_W-1:0] w_shl;
   logic [2*HALF_W-1:0] w_shr;

   // Shifting a doubled copy makes the wrapped bits fall into the kept half.
   assign w_dbl  = {i_data, i_data};
   assign w_shl  = w_dbl << i_amt;
   assign w_shr  = w_dbl >> i_amt;
   assign o_data = i_right ? w_shr[HALF_W-1:0] : w_shl[2*HALF_W-1:HALF_W];

endmodule

// File: rtl/key_cd_schedule_reg.sv
// C/D half-key register: loads C0/D0 on Start and steps them through every round,
// presenting one rotated (Cn, Dn) pair per cycle.
module key_cd_schedule_reg
   import key_sched_pkg::*;
#(
   parameter int unsigned HALF_W = 28,
   parameter int unsigned ROUNDS = 16,
   parameter int unsigned RW     = $clog2(ROUNDS + 1)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Decrypt,
   input  logic              Hold,
   input  logic [HALF_W-1:0] C0,
   input  logic [HALF_W-1:0] D0,
   output logic [HALF_W-1:0] C_out,
   output logic [HALF_W-1:0] D_out,
   output logic [RW-1:0]     Round,
   output logic              Valid,
   output logic              Busy,
   output logic              Done
);

   localparam int unsigned   AW        = (HALF_W > 1) ? $clog2(HALF_W) : 1;
   localparam logic [RW-1:0] LastRound = RW'(ROUNDS);

   state_e              r_state;
   state_e              w_state_d;
   logic [HALF_W-1:0]   r_c;
   logic [HALF_W-1:0]   r_d;
   logic [RW-1:0]       r_round;
   logic                r_decrypt;

   logic                w_load;
   logic                w_step;
   logic                w_finish;
   logic [HALF_W-1:0]   w_src_c;
   logic [HALF_W-1:0]   w_src_d;
   logic [HALF_W-1:0]   w_rot_c;
   logic [HALF_W-1:0]   w_rot_d;
   logic [AW-1:0]       w_amt;
   logic                w_right;

   always_comb begin
      w_state_d = r_state;
      w_load    = 1'b0;
      w_step    = 1'b0;
      w_finish  = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (Start) begin
               w_state_d = StRun;
               w_load    = 1'b1;
            end
         end
         StRun: begin
            if (!Hold) begin
               if (r_round == LastRound) begin
                  w_state_d = StIdle;
                  w_finish  = 1'b1;
               end else begin
                  w_step = 1'b1;
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // In IDLE the rotators see the raw inputs so round 1 is ready at the Start edge.
   always_comb begin
      w_src_c = r_c;
      w_src_d = r_d;
      w_right = 1'b0;
      w_amt   = '0;
      if (r_state == StIdle) begin
         w_src_c = C0;
         w_src_d = D0;
         w_amt   = Decrypt ? AW'(total_shift(ROUNDS, HALF_W)) : AW'(shift_amt(1, ROUNDS));
      end else begin
         w_right = r_decrypt;
         w_amt   = r_decrypt ? AW'(shift_amt(ROUNDS + 1 - 32'(r_round), ROUNDS))
                             : AW'(shift_amt(32'(r_round) + 1, ROUNDS));
      end
   end

   key_half_rotate #(
      .HALF_W (HALF_W),
      .AW     (AW)
   ) u_rot_c (
      .i_data  (w_src_c),
      .i_amt   (w_amt),
      .i_right (w_right),
      .o_data  (w_rot_c)
   );

   key_half_rotate #(
      .HALF_W (HALF_W),
      .AW     (AW)
   ) u_rot_d (
      .i_data  (w_src_d),
      .i_amt   (w_amt),
      .i_right (w_right),
      .o_data  (w_rot_d)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state   <= StIdle;
         r_c       <= '0;
         r_d       <= '0;
         r_round   <= '0;
         r_decrypt <= 1'b0;
      end else begin
         r_state <= w_state_d;
         if (w_load) begin
            r_c       <= w_rot_c;
            r_d       <= w_rot_d;
            r_round   <= RW'(1);
            r_decrypt <= Decrypt;
         end else if (w_step) begin
            r_c     <= w_rot_c;
            r_d     <= w_rot_d;
            r_round <= r_round + RW'(1);
         end else if (w_finish) begin
            r_round <= '0;
         end
      end
   end

   always_comb begin
      C_out = r_c;
      D_out = r_d;
      Round = r_round;
      Valid = (r_state == StRun);
      Busy  = (r_state == StRun);
      Done  = (r_state == StRun) && (r_round == LastRound) && !Hold;
   end

endmodule

// File: tb/tb_key_cd_schedule_reg.sv
// Self-checking bench for key_cd_schedule_reg: directed vectors plus randomized runs
// compared against a cumulative-rotation reference model.
module tb_key_cd_schedule_reg;

   localparam int W  = 28;
   localparam int R  = 16;
   localparam int RW = $clog2(R + 1);

   logic          Clk = 1'b0;
   logic          Reset, Start, Decrypt, Hold;
   logic [W-1:0]  C0, D0, C_out, D_out;
   logic [RW-1:0] Round;
   logic          Valid, Busy, Done;

   logic          Start64, Decrypt64, Hold64;
   logic [63:0]   C0_64, D0_64, C_out64, D_out64;
   logic [RW-1:0] Round64;
   logic          Valid64, Busy64, Done64;

   int tests = 0;
   int fails = 0;

   key_cd_schedule_reg #(.HALF_W(W), .ROUNDS(R)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Decrypt(Decrypt), .Hold(Hold),
      .C0(C0), .D0(D0), .C_out(C_out), .D_out(D_out), .Round(Round),
      .Valid(Valid), .Busy(Busy), .Done(Done)
   );

   key_cd_schedule_reg #(.HALF_W(64), .ROUNDS(R)) dut64 (
      .Clk(Clk), .Reset(Reset), .Start(Start64), .Decrypt(Decrypt64), .Hold(Hold64),
      .C0(C0_64), .D0(D0_64), .C_out(C_out64), .D_out(D_out64), .Round(Round64),
      .Valid(Valid64), .Busy(Busy64), .Done(Done64)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   function automatic int s_of(input int r);
      return (r == 1 || r == 2 || r == R / 2 + 1 || r == R) ? 1 : 2;
   endfunction

   // Net left-rotation of round r relative to C0.
   function automatic int off_of(input int r, input bit dec);
      int acc = 0;
      if (!dec) begin
         for (int k = 1; k <= r; k++) acc += s_of(k);
      end else begin
         acc = 2 * R - 4;
         for (int j = 2; j <= r; j++) acc -= s_of(R + 2 - j);
      end
      return ((acc % W) + W) % W;
   endfunction

   function automatic logic [63:0] rotl(input logic [63:0] x, input int n, input int w);
      logic [63:0] mask;
      logic [63:0] v;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      v    = x & mask;
      for (int i = 0; i < n; i++) v = ((v << 1) | {63'd0, v[w-1]}) & mask;
      return v;
   endfunction

   function automatic logic [W-1:0] model(input logic [W-1:0] k0, input int r, input bit dec);
      return W'(rotl(64'(k0), off_of(r, dec), W));
   endfunction

   task automatic chk_round(input logic [W-1:0] ec, ed, input int r, input bit done);
      chk($sformatf("c_r%0d", r), 64'(C_out), 64'(ec));
      chk($sformatf("d_r%0d", r), 64'(D_out), 64'(ed));
      chk($sformatf("round_r%0d", r), 64'(Round), 64'(r));
      chk($sformatf("valid_r%0d", r), 64'(Valid), 64'd1);
      chk($sformatf("busy_r%0d", r), 64'(Busy), 64'd1);
      chk($sformatf("done_r%0d", r), 64'(Done), 64'(done));
   endtask

   task automatic chk_idle(input string tag, input logic [W-1:0] ec, ed);
      chk({tag, "_c"}, 64'(C_out), 64'(ec));
      chk({tag, "_d"}, 64'(D_out), 64'(ed));
      chk({tag, "_round"}, 64'(Round), 64'd0);
      chk({tag, "_valid"}, 64'(Valid), 64'd0);
      chk({tag, "_busy"}, 64'(Busy), 64'd0);
      chk({tag, "_done"}, 64'(Done), 64'd0);
   endtask

   task automatic directed(input logic [W-1:0] c0, d0, input bit dec,
                           input logic [W-1:0] e1, e2, e3, e16, ed1);
      C0 = c0; D0 = d0; Decrypt = dec; Start = 1'b1; Hold = 1'b0;
      step();
      Start = 1'b0;
      #1;
      chk("dir_c1", 64'(C_out), 64'(e1));
      chk("dir_d1", 64'(D_out), 64'(ed1));
      chk("dir_round1", 64'(Round), 64'd1);
      chk("dir_valid1", 64'(Valid), 64'd1);
      step(); #1;
      chk("dir_c2", 64'(C_out), 64'(e2));
      step(); #1;
      chk("dir_c3", 64'(C_out), 64'(e3));
      repeat (13) step();
      #1;
      chk("dir_c16", 64'(C_out), 64'(e16));
      chk("dir_round16", 64'(Round), 64'(R));
      chk("dir_done16", 64'(Done), 64'd1);
      step(); #1;
      chk("dir_end_valid", 64'(Valid), 64'd0);
      chk("dir_end_round", 64'(Round), 64'd0);
      chk("dir_end_c", 64'(C_out), 64'(e16));
   endtask

   // One run checked every cycle; optional hold, ignored restart, mid-run reset.
   task automatic do_run(input logic [W-1:0] c0, d0, input bit dec, input int hold_at,
                         input int hold_n, input int start_at, input int reset_at,
                         input bit keep_start);
      logic [W-1:0] ec, ed;
      C0 = c0; D0 = d0; Decrypt = dec; Start = 1'b1; Hold = 1'b0;
      step();
      for (int r = 1; r <= R; r++) begin
         Start   = keep_start || (r == start_at);
         C0      = W'($urandom);
         D0      = W'($urandom);
         Decrypt = 1'($urandom);
         ec      = model(c0, r, dec);
         ed      = model(d0, r, dec);
         if (r == reset_at) begin
            Start = 1'b0;
            Reset = 1'b1;
            step();
            Reset = 1'b0;
            #1;
            chk_idle("reset", '0, '0);
            return;
         end
         if (r == hold_at) begin
            repeat (hold_n) begin
               Hold = 1'b1;
               #1;
               chk_round(ec, ed, r, 1'b0);
               step();
            end
         end
         Hold = 1'b0;
         #1;
         chk_round(ec, ed, r, r == R);
         step();
      end
      #1;
      chk_idle("end", model(c0, R, dec), model(d0, R, dec));
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; Decrypt = 1'b0; Hold = 1'b0; C0 = '0; D0 = '0;
      Start64 = 1'b0; Decrypt64 = 1'b0; Hold64 = 1'b0; C0_64 = '0; D0_64 = '0;
      repeat (2) step();
      #1;
      chk_idle("rst", '0, '0);
      chk("rst64_valid", 64'(Valid64), 64'd0);
      chk("rst64_c", C_out64, 64'd0);
      Reset = 1'b0;

      C0_64 = 64'h8000000000000000;
      D0_64 = {$urandom, $urandom};
      Start64 = 1'b1;
      step();
      Start64 = 1'b0;
      #1;
      chk("w64_c1", C_out64, 64'h1);
      chk("w64_d1", D_out64, rotl(D0_64, 1, 64));
      chk("w64_round1", 64'(Round64), 64'd1);

      directed(28'h00000FF, 28'h00001FC, 1'b0, 28'h00001FE, 28'h00003FC, 28'h0000FF0,
               28'h00000FF, 28'h00003F8);
      directed(28'h00000FF, 28'h00001FC, 1'b1, 28'h00000FF, 28'h800007F, 28'hE00001F,
               28'h00001FE, 28'h00001FC);
      directed(28'h8000000, 28'h0000000, 1'b0, 28'h0000001, 28'h0000002, 28'h0000008,
               28'h8000000, 28'h0000000);

      do_run(28'h00000FF, 28'h00001FC, 1'b0, 5, 3, 0, 0, 1'b0);
      do_run(W'($urandom), W'($urandom), 1'b0, 0, 0, 4, 0, 1'b0);
      do_run(W'($urandom), W'($urandom), 1'b1, 0, 0, 0, 8, 1'b0);
      do_run(W'($urandom), W'($urandom), 1'b0, 0, 0, 0, 0, 1'b0);

      do_run(W'($urandom), W'($urandom), 1'b0, 0, 0, 0, 0, 1'b1);
      do_run(W'($urandom), W'($urandom), 1'b1, 0, 0, 0, 0, 1'b1);
      do_run(W'($urandom), W'($urandom), 1'b0, 0, 0, 0, 0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         do_run(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(1, R)),
                int'($urandom_range(0, 3)), int'($urandom_range(1, R)), 0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/key_cd_schedule_reg.md
# key_cd_schedule_reg

Parametrised successor to the C/D half-key register in the DES key-schedule datapath. It latches the C0/D0 halves after PC-1 and steps them through all rounds autonomously. Each cycle it applies the per-round rotation schedule, in the left direction for encryption or the right direction for decryption. It emits one (Cn, Dn) pair per cycle with a round index and valid strobe, feeding PC-2. It is generalised in half-width so the same block serves the 56-bit DES and the 128-bit expanded variant.

## Interface
Parameters:
- HALF_W, 28, width of each key half (64 for the 128-bit variant).
- ROUNDS, 16, number of rounds; must be ≥ 4.
- RW, $clog2(ROUNDS+1), width of round index.

Ports:
- Clk  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- Start  in  1  load request; sampled only in IDLE.
- Decrypt  in  1  mode, sampled with Start: 0 = encrypt (rotate left), 1 = decrypt (rotate right).
- Hold  in  1  stall; freezes state and outputs while high in RUN.
- C0  in  HALF_W  initial C half.
- D0  in  HALF_W  initial D half.
- C_out  out  HALF_W  current round C half.
- D_out  out  HALF_W  current round D half.
- Round  out  RW  current round index, 1..ROUNDS; 0 when idle.
- Valid  out  1  C_out/D_out/Round valid for this cycle.
- Busy  out  1  high in RUN.
- Done  out  1  one-cycle pulse coincident with the last round.

## Operation
- Shift amount s(r) for r = 1..ROUNDS: 1 if r ∈ {1, 2, ROUNDS/2+1, ROUNDS}, else 2. For ROUNDS=16 this matches DES. TOTAL = 2·ROUNDS−4, taken mod HALF_W.
- States: IDLE, RUN.
- IDLE → RUN on Start=1.
- RUN → IDLE after round ROUNDS is presented with Hold=0.
- Encrypt: round 1 = rotl(C0, s(1)). Round r = rotl(round r−1, s(r)).
- Decrypt: round 1 = rotl(C0, TOTAL), which equals C0 when TOTAL ≡ 0 mod HALF_W. Round r = rotr(round r−1, s(ROUNDS+2−r)).
- D follows the same rule as C.
- C0, D0 and Decrypt are captured on the Start edge. Input changes after that have no effect until the next Start.
- Start during RUN is ignored; there is no restart and no queueing.
- Hold=1 in RUN: the register, Round, Valid and Busy are unchanged. Done is suppressed until the final round advances.
- Hold in IDLE has no effect.
- Rotation is modulo HALF_W with no bit loss. The MSB wraps to the LSB on left rotation, and the reverse on right rotation.

## Timing
- Reset values: C_out=0, D_out=0, Round=0, Valid=0, Busy=0, Done=0, state=IDLE.
- Reset overrides every other input in the same cycle, including mid-RUN. The run is abandoned and nothing is flushed.
- Start sampled high at edge T: round 1 is visible after T with Valid=1, Round=1, Busy=1.
- Without Hold, round r is visible after edge T+r−1, and round ROUNDS after T+ROUNDS−1 with Done=1.
- After the next edge: Valid=0, Busy=0, Round=0, Done=0. C_out/D_out keep the last round's values.
- Start may be asserted in that same following cycle. It is accepted, so back-to-back runs have one idle cycle between them.
- Valid is continuous across a run except that it stays high, frozen, during Hold.
- Latency from Start to first key is 1 cycle. A full run takes ROUNDS cycles plus Hold cycles.

## Structure
- Shared package key_sched_pkg holds:
  - the state enum (IDLE, RUN);
  - function shift_amt(r, ROUNDS);
  - function total_shift(ROUNDS, HALF_W).
- One sub-module, key_half_rotate: combinational rotate of HALF_W bits by 0..HALF_W−1 in either direction, instantiated twice (C and D).
- The top level holds the FSM, the round counter and the two HALF_W registers.

## Test plan
- Encrypt, C0=28'h00000FF, D0=28'h00001FC, Start one cycle. Required sequence:
  - Round 1: C_out=28'h00001FE, D_out=28'h00003F8.
  - Round 2: C_out=28'h00003FC.
  - Round 3: C_out=28'h0000FF0.
  - Round 16: C_out=28'h00000FF, since the total of 28 rotates gives full wrap. Done=1 in that cycle.
- Decrypt, C0=28'h00000FF:
  - Round 1: C_out=28'h00000FF.
  - Round 2: C_out=28'h800007F.
  - Round 16 == encrypt round 1 (28'h00001FE).
- Wrap: encrypt with C0=28'h8000000 → round 1 C_out=28'h0000001. Also run HALF_W=64 with C0=64'h8000000000000000 → round 1 C_out=64'h1.
- Hold=1 for 3 cycles while Round=5 → C_out, Round=5 and Valid=1 are frozen for 3 cycles, then Round=6. Done arrives 3 cycles late.
- Start reasserted at Round=4 with new C0 → ignored and the sequence is unchanged. Reset at Round=8 → next cycle all outputs 0 and state IDLE. A subsequent Start restarts at Round 1.
- Back-to-back: Start held continuously → runs separated by exactly one Valid=0 cycle after each Done.
